// File: rtl/sync_vg_mode_ctrl.sv
// Mode sequencer for the sync generator: shadow timing registers, commit-time
// validation, vsync-aligned swap into the active set and a generator reset hold.
module sync_vg_mode_ctrl #(
  parameter int X_BITS     = 12,
  parameter int Y_BITS     = 12,
  parameter int D_BITS     = 12,
  parameter int RST_CYCLES = 4,
  parameter int TIMEOUT    = 2000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [3:0]        addr,
  input  logic [D_BITS-1:0] wdata,
  input  logic              vs_in,
  output logic              busy,
  output logic              err,
  output logic              applied,
  output logic              gen_reset,
  output logic              interlaced_o,
  output logic [X_BITS-1:0] h_total_o,
  output logic [X_BITS-1:0] h_fp_o,
  output logic [X_BITS-1:0] h_bp_o,
  output logic [X_BITS-1:0] h_sync_o,
  output logic [X_BITS-1:0] hv_offset_0_o,
  output logic [X_BITS-1:0] hv_offset_1_o,
  output logic [Y_BITS-1:0] v_total_0_o,
  output logic [Y_BITS-1:0] v_fp_0_o,
  output logic [Y_BITS-1:0] v_bp_0_o,
  output logic [Y_BITS-1:0] v_sync_0_o,
  output logic [Y_BITS-1:0] v_total_1_o,
  output logic [Y_BITS-1:0] v_fp_1_o,
  output logic [Y_BITS-1:0] v_bp_1_o,
  output logic [Y_BITS-1:0] v_sync_1_o,
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_VALIDATE = 3'd1,
    S_WAIT_VS  = 3'd2,
    S_APPLY    = 3'd3,
    S_HOLD     = 3'd4
  } state_e;

  localparam int SW = ((X_BITS > Y_BITS) ? X_BITS : Y_BITS) + 2;
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [RW-1:0] RCNT_INIT = RW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  localparam logic [X_BITS-1:0] H_TOTAL_RST = X_BITS'(800);
  localparam logic [X_BITS-1:0] H_FP_RST    = X_BITS'(16);
  localparam logic [X_BITS-1:0] H_BP_RST    = X_BITS'(48);
  localparam logic [X_BITS-1:0] H_SYNC_RST  = X_BITS'(96);
  localparam logic [Y_BITS-1:0] V_TOTAL_RST = Y_BITS'(525);
  localparam logic [Y_BITS-1:0] V_FP_RST    = Y_BITS'(10);
  localparam logic [Y_BITS-1:0] V_BP_RST    = Y_BITS'(33);
  localparam logic [Y_BITS-1:0] V_SYNC_RST  = Y_BITS'(2);

  state_e            state_q;
  logic [RW-1:0]     rcnt_q;
  logic [TW-1:0]     tmo_q;
  logic              vs_q, vs_prev_q;

  logic              sh_il_q;
  logic [X_BITS-1:0] sh_h_total_q, sh_h_fp_q, sh_h_bp_q, sh_h_sync_q;
  logic [X_BITS-1:0] sh_hv0_q, sh_hv1_q;
  logic [Y_BITS-1:0] sh_vt0_q, sh_vfp0_q, sh_vbp0_q, sh_vs0_q;
  logic [Y_BITS-1:0] sh_vt1_q, sh_vfp1_q, sh_vbp1_q, sh_vs1_q;

  logic [SW-1:0]     h_sum, v0_sum, v1_sum;
  logic              h_ok, v0_ok, v1_ok, cfg_ok;
  logic              vs_edge;

  // Sums are widened by two bits so three fields can never wrap past the total.
  always_comb begin
    h_sum  = SW'(sh_h_sync_q) + SW'(sh_h_bp_q) + SW'(sh_h_fp_q);
    v0_sum = SW'(sh_vs0_q) + SW'(sh_vbp0_q) + SW'(sh_vfp0_q);
    v1_sum = SW'(sh_vs1_q) + SW'(sh_vbp1_q) + SW'(sh_vfp1_q);
    h_ok   = (sh_h_total_q >= X_BITS'(2)) && (h_sum < SW'(sh_h_total_q)) &&
             (sh_hv0_q < sh_h_total_q) && (sh_hv1_q < sh_h_total_q);
    v0_ok  = (sh_vt0_q >= Y_BITS'(2)) && (v0_sum < SW'(sh_vt0_q));
    v1_ok  = (sh_vt1_q >= Y_BITS'(2)) && (v1_sum < SW'(sh_vt1_q));
    cfg_ok = h_ok && v0_ok && (v1_ok || !sh_il_q);
  end

  assign vs_edge = vs_q & ~vs_prev_q;
  assign busy    = (state_q != S_IDLE);
  assign state_o = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_HOLD;
      rcnt_q        <= RCNT_INIT;
      tmo_q         <= '0;
      vs_q          <= 1'b0;
      vs_prev_q     <= 1'b0;
      err           <= 1'b0;
      applied       <= 1'b0;
      gen_reset     <= 1'b1;
      sh_il_q       <= 1'b0;
      sh_h_total_q  <= H_TOTAL_RST;
      sh_h_fp_q     <= H_FP_RST;
      sh_h_bp_q     <= H_BP_RST;
      sh_h_sync_q   <= H_SYNC_RST;
      sh_hv0_q      <= '0;
      sh_hv1_q      <= '0;
      sh_vt0_q      <= V_TOTAL_RST;
      sh_vfp0_q     <= V_FP_RST;
      sh_vbp0_q     <= V_BP_RST;
      sh_vs0_q      <= V_SYNC_RST;
      sh_vt1_q      <= V_TOTAL_RST;
      sh_vfp1_q     <= V_FP_RST;
      sh_vbp1_q     <= V_BP_RST;
      sh_vs1_q      <= V_SYNC_RST;
      interlaced_o  <= 1'b0;
      h_total_o     <= H_TOTAL_RST;
      h_fp_o        <= H_FP_RST;
      h_bp_o        <= H_BP_RST;
      h_sync_o      <= H_SYNC_RST;
      hv_offset_0_o <= '0;
      hv_offset_1_o <= '0;
      v_total_0_o   <= V_TOTAL_RST;
      v_fp_0_o      <= V_FP_RST;
      v_bp_0_o      <= V_BP_RST;
      v_sync_0_o    <= V_SYNC_RST;
      v_total_1_o   <= V_TOTAL_RST;
      v_fp_1_o      <= V_FP_RST;
      v_bp_1_o      <= V_BP_RST;
      v_sync_1_o    <= V_SYNC_RST;
    end else begin
      vs_q      <= vs_in;
      vs_prev_q <= vs_q;
      applied   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (wr) begin
            case (addr)
              4'd0:  sh_h_total_q <= wdata[X_BITS-1:0];
              4'd1:  sh_h_fp_q    <= wdata[X_BITS-1:0];
              4'd2:  sh_h_bp_q    <= wdata[X_BITS-1:0];
              4'd3:  sh_h_sync_q  <= wdata[X_BITS-1:0];
              4'd4:  sh_vt0_q     <= wdata[Y_BITS-1:0];
              4'd5:  sh_vfp0_q    <= wdata[Y_BITS-1:0];
              4'd6:  sh_vbp0_q    <= wdata[Y_BITS-1:0];
              4'd7:  sh_vs0_q     <= wdata[Y_BITS-1:0];
              4'd8:  sh_vt1_q     <= wdata[Y_BITS-1:0];
              4'd9:  sh_vfp1_q    <= wdata[Y_BITS-1:0];
              4'd10: sh_vbp1_q    <= wdata[Y_BITS-1:0];
              4'd11: sh_vs1_q     <= wdata[Y_BITS-1:0];
              4'd12: sh_hv0_q     <= wdata[X_BITS-1:0];
              4'd13: sh_hv1_q     <= wdata[X_BITS-1:0];
              4'd14: sh_il_q      <= wdata[0];
              4'd15: state_q      <= S_VALIDATE;
            endcase
          end
        end
        S_VALIDATE: begin
          if (cfg_ok) begin
            err     <= 1'b0;
            tmo_q   <= '0;
            state_q <= S_WAIT_VS;
          end else begin
            err     <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_WAIT_VS: begin
          // Raising gen_reset here makes the APPLY cycle part of the reset window.
          if (vs_edge || (tmo_q == TMO_LAST)) begin
            gen_reset <= 1'b1;
            state_q   <= S_APPLY;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        S_APPLY: begin
          interlaced_o  <= sh_il_q;
          h_total_o     <= sh_h_total_q;
          h_fp_o        <= sh_h_fp_q;
          h_bp_o        <= sh_h_bp_q;
          h_sync_o      <= sh_h_sync_q;
          hv_offset_0_o <= sh_hv0_q;
          hv_offset_1_o <= sh_hv1_q;
          v_total_0_o   <= sh_vt0_q;
          v_fp_0_o      <= sh_vfp0_q;
          v_bp_0_o      <= sh_vbp0_q;
          v_sync_0_o    <= sh_vs0_q;
          v_total_1_o   <= sh_vt1_q;
          v_fp_1_o      <= sh_vfp1_q;
          v_bp_1_o      <= sh_vbp1_q;
          v_sync_1_o    <= sh_vs1_q;
          gen_reset     <= 1'b1;
          rcnt_q        <= RCNT_INIT;
          state_q       <= S_HOLD;
        end
        S_HOLD: begin
          if (rcnt_q == '0) begin
            gen_reset <= 1'b0;
            applied   <= 1'b1;
            state_q   <= S_IDLE;
          end else begin
            rcnt_q <= rcnt_q - RW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_vg_mode_ctrl.sv
// Directed bench for sync_vg_mode_ctrl: expected active sets and gen_reset
// window lengths are queued at stimulus time and popped by negedge monitors.
module tb_sync_vg_mode_ctrl;
  localparam int W = 169;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr = 1'b0;
  logic [3:0]  addr = '0;
  logic [11:0] wdata = '0;
  logic        vs_in = 1'b0;
  logic        busy, err, applied, gen_reset, interlaced_o;
  logic [11:0] h_total_o, h_fp_o, h_bp_o, h_sync_o, hv_offset_0_o, hv_offset_1_o;
  logic [11:0] v_total_0_o, v_fp_0_o, v_bp_0_o, v_sync_0_o;
  logic [11:0] v_total_1_o, v_fp_1_o, v_bp_1_o, v_sync_1_o;
  logic [2:0]  state_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  int           grst_q[$];
  logic [11:0]  sh [0:13];
  logic         sh_il;

  sync_vg_mode_ctrl #(.X_BITS(12), .Y_BITS(12), .D_BITS(12), .RST_CYCLES(4), .TIMEOUT(50)) dut (
    .clk(clk), .reset(reset), .wr(wr), .addr(addr), .wdata(wdata), .vs_in(vs_in),
    .busy(busy), .err(err), .applied(applied), .gen_reset(gen_reset),
    .interlaced_o(interlaced_o), .h_total_o(h_total_o), .h_fp_o(h_fp_o), .h_bp_o(h_bp_o),
    .h_sync_o(h_sync_o), .hv_offset_0_o(hv_offset_0_o), .hv_offset_1_o(hv_offset_1_o),
    .v_total_0_o(v_total_0_o), .v_fp_0_o(v_fp_0_o), .v_bp_0_o(v_bp_0_o), .v_sync_0_o(v_sync_0_o),
    .v_total_1_o(v_total_1_o), .v_fp_1_o(v_fp_1_o), .v_bp_1_o(v_bp_1_o), .v_sync_1_o(v_sync_1_o),
    .state_o(state_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pack_model();
    return {sh_il, sh[0], sh[1], sh[2], sh[3], sh[12], sh[13],
            sh[4], sh[5], sh[6], sh[7], sh[8], sh[9], sh[10], sh[11]};
  endfunction

  task automatic model_defaults();
    sh[0] = 800; sh[1] = 16; sh[2] = 48; sh[3] = 96;
    for (int i = 4; i < 12; i += 4) begin
      sh[i] = 525; sh[i+1] = 10; sh[i+2] = 33; sh[i+3] = 2;
    end
    sh[12] = 0; sh[13] = 0; sh_il = 1'b0;
  endtask

  // Driver tasks: entered and left 1 time unit after a rising edge.
  task automatic wr_reg(input logic [3:0] a, input logic [11:0] d, input bit upd);
    wr = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    wr = 1'b0;
    if (upd && a < 4'd14) sh[a] = d;
    if (upd && a == 4'd14) sh_il = d[0];
  endtask

  task automatic vs_pulse();
    vs_in = 1'b1;
    @(posedge clk); #1;
    vs_in = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk); #1;
      if (!busy) done = 1;
    end
    chk(name, W'(done), W'(1));
  endtask

  // Scoreboard monitors
  logic [W-1:0] act_pack;
  assign act_pack = {interlaced_o, h_total_o, h_fp_o, h_bp_o, h_sync_o, hv_offset_0_o,
                     hv_offset_1_o, v_total_0_o, v_fp_0_o, v_bp_0_o, v_sync_0_o,
                     v_total_1_o, v_fp_1_o, v_bp_1_o, v_sync_1_o};

  always @(negedge clk) begin
    if (!reset && applied === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_apply", W'(1), W'(0));
      else chk("apply_actives", act_pack, exp_q.pop_front());
    end
  end

  int grst_run = 0;
  always @(negedge clk) begin
    if (reset) grst_run = 0;
    else if (gen_reset === 1'b1) grst_run++;
    else if (grst_run > 0) begin
      if (grst_q.size() == 0) chk("unexpected_gen_reset", W'(grst_run), W'(0));
      else chk("gen_reset_len", W'(grst_run), W'(grst_q.pop_front()));
      grst_run = 0;
    end
  end

  initial begin
    int wait_cnt;
    bit seen;
    model_defaults();

    // 1: reset and release
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gen_reset", W'(gen_reset), W'(1));
    chk("rst_applied", W'(applied), W'(0));
    chk("rst_err", W'(err), W'(0));
    chk("rst_busy", W'(busy), W'(1));
    chk("rst_actives", act_pack, pack_model());
    exp_q.push_back(pack_model());
    grst_q.push_back(4);
    reset = 1'b0;
    wait_idle("idle_after_reset");

    // 2: new mode, vsync-aligned apply
    wr_reg(0, 858, 1); wr_reg(1, 16, 1); wr_reg(2, 60, 1); wr_reg(3, 62, 1);
    wr_reg(4, 525, 1); wr_reg(5, 9, 1); wr_reg(6, 30, 1); wr_reg(7, 6, 1);
    exp_q.push_back(pack_model());
    grst_q.push_back(5);
    wr_reg(15, 0, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("pre_edge_h_total", W'(h_total_o), W'(800));
    chk("pre_edge_err", W'(err), W'(0));
    vs_pulse();
    @(posedge clk); #1;
    chk("apply_cycle_gen_reset", W'(gen_reset), W'(1));
    chk("apply_cycle_h_total", W'(h_total_o), W'(800));
    @(posedge clk); #1;
    chk("post_apply_h_total", W'(h_total_o), W'(858));
    wait_idle("idle_after_t2");

    // 3: horizontal overflow rejected, then a valid commit clears err
    wr_reg(0, 100, 1); wr_reg(1, 60, 1); wr_reg(2, 50, 1); wr_reg(3, 50, 1);
    wr_reg(15, 0, 0);
    @(posedge clk); #1;
    chk("h_fail_err", W'(err), W'(1));
    chk("h_fail_busy", W'(busy), W'(0));
    chk("h_fail_actives", W'(h_total_o), W'(858));
    wr_reg(0, 858, 1); wr_reg(1, 16, 1); wr_reg(2, 60, 1); wr_reg(3, 62, 1);
    exp_q.push_back(pack_model());
    grst_q.push_back(5);
    wr_reg(15, 0, 0);
    @(posedge clk); #1;
    chk("h_recover_err", W'(err), W'(0));
    vs_pulse();
    wait_idle("idle_after_t3");

    // 4: set-1 checked only when interlaced; 5: timeout apply
    wr_reg(14, 1, 1); wr_reg(8, 0, 1);
    wr_reg(15, 0, 0);
    @(posedge clk); #1;
    chk("v1_fail_err", W'(err), W'(1));
    wr_reg(14, 0, 1);
    exp_q.push_back(pack_model());
    grst_q.push_back(5);
    wr_reg(15, 0, 0);
    @(posedge clk); #1;
    chk("v1_ignored_err", W'(err), W'(0));
    wait_cnt = 0;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (gen_reset) seen = 1;
      else if (state_o == 3'd2) wait_cnt++;
    end
    chk("timeout_wait_cycles", W'(wait_cnt), W'(50));
    @(posedge clk); #1;
    wait_idle("idle_after_t5");

    // 6a: write during WAIT_VS is dropped
    exp_q.push_back(pack_model());
    grst_q.push_back(5);
    wr_reg(15, 0, 0);
    @(posedge clk); #1;
    wr_reg(0, 1000, 0);
    vs_pulse();
    wait_idle("idle_after_t6a");

    // 6b: reset while waiting aborts the commit
    wr_reg(15, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    model_defaults();
    chk("midrst_busy", W'(busy), W'(1));
    chk("midrst_gen_reset", W'(gen_reset), W'(1));
    chk("midrst_actives", act_pack, pack_model());
    exp_q.push_back(pack_model());
    grst_q.push_back(4);
    reset = 1'b0;
    wait_idle("idle_after_t6b");
    repeat (60) @(posedge clk);
    #1;
    chk("no_late_apply_busy", W'(busy), W'(0));
    chk("no_late_apply_h_total", W'(h_total_o), W'(800));

    repeat (5) @(posedge clk);
    #1;
    chk("exp_q_drained", W'(exp_q.size()), W'(0));
    chk("grst_q_drained", W'(grst_q.size()), W'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sync_vg_mode_ctrl.md
Name: sync_vg_mode_ctrl

Overview:
Configuration sequencer for the video sync/timing generator. It holds a shadow copy of all timing parameters, written through a simple register bus, and validates a committed mode. It then waits for a frame boundary (rising edge of the generator's vsync) and swaps the shadow set into the active outputs. While the swap happens, it holds the generator in reset for a programmable number of cycles, so timing never changes mid-frame and the generator restarts cleanly.

Parameters:
X_BITS, 12, width of horizontal timing fields
Y_BITS, 12, width of vertical timing fields
D_BITS, 12, write-data width; must be >= X_BITS and >= Y_BITS; fields take the LSBs
RST_CYCLES, 4, generator-reset hold length in clk cycles (>=1)
TIMEOUT, 2000000, cycles to wait for a vsync edge before applying anyway (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
wr  in  1  register write strobe, single cycle
addr  in  4  register address (map below)
wdata  in  D_BITS  write data
vs_in  in  1  generator vsync output (same clk domain)
busy  out  1  high outside IDLE; writes are dropped while high
err  out  1  sticky validation failure; cleared by the next successful validation or by reset
applied  out  1  one-cycle pulse when the generator reset is released
gen_reset  out  1  drives the generator's reset input
interlaced_o  out  1  active interlaced flag
h_total_o, h_fp_o, h_bp_o, h_sync_o, hv_offset_0_o, hv_offset_1_o  out  X_BITS each  active horizontal timing
v_total_0_o, v_fp_0_o, v_bp_0_o, v_sync_0_o, v_total_1_o, v_fp_1_o, v_bp_1_o, v_sync_1_o  out  Y_BITS each  active vertical timing

Behaviour:
- Register map (shadow registers):
  - Addresses 0-3: h_total, h_fp, h_bp, h_sync.
  - Addresses 4-7: v_total_0, v_fp_0, v_bp_0, v_sync_0.
  - Addresses 8-11: v_total_1, v_fp_1, v_bp_1, v_sync_1.
  - Addresses 12-13: hv_offset_0, hv_offset_1.
  - Address 14: interlaced (wdata[0]).
  - Address 15: commit (data ignored).
- Write handling: a write is accepted only in IDLE (busy=0). A shadow write updates the register on the next edge. Writes and commits while busy are discarded with no side effect.
- Reset values: shadows and actives are 800/16/48/96 horizontal, 525/10/33/2 for both vertical sets, hv_offsets 0, interlaced 0. err=0, applied=0, gen_reset=1. State = HOLD with counter=RST_CYCLES-1.
- State IDLE: a commit moves to VALIDATE next cycle.
- State VALIDATE (1 cycle): evaluate the shadows using (max width + 2)-bit sums, no wrap.
  - Horizontal checks: h_total >= 2; h_sync + h_bp + h_fp < h_total; hv_offset_0 < h_total; hv_offset_1 < h_total.
  - Set-0 vertical checks: v_total_0 >= 2; v_sync_0 + v_bp_0 + v_fp_0 < v_total_0.
  - Set-1 vertical checks: the same rules on set 1, applied only if interlaced=1.
  - Fail: err<=1, go to IDLE; actives unchanged.
  - Pass: err<=0, go to WAIT_VS, timeout counter cleared.
- State WAIT_VS:
  - vs_in is registered once; an edge is vs_q=1 while the previous sample was 0.
  - An edge, or timeout counter == TIMEOUT-1, moves to APPLY. An edge and timeout in the same cycle count as a single transition.
  - Otherwise the counter increments.
- State APPLY (1 cycle): all shadows are copied to the actives, gen_reset<=1, counter<=RST_CYCLES-1, go to HOLD. Actives change only on this edge.
- State HOLD: gen_reset=1. When the counter reaches 0: gen_reset<=0, applied<=1 for one cycle, go to IDLE. Otherwise the counter decrements.
  - Total gen_reset high time = RST_CYCLES+1 cycles after a commit.
  - Total gen_reset high time = RST_CYCLES cycles after a reset release, where applied also pulses.
- Reset mid-operation: aborts any state; all registers return to their reset values; any pending commit is lost.
- busy = (state != IDLE), combinational from the state register.

Test Plan:
1. Release reset, idle vs_in -> gen_reset high for 4 cycles, applied pulses once, actives = 800/16/48/96, 525/10/33/2.
2. Write h_total=858, h_fp=16, h_bp=60, h_sync=62, v_total_0=525, v_fp_0=9, v_bp_0=30, v_sync_0=6, then commit; pulse vs_in 10 cycles later -> actives unchanged before the edge; APPLY occurs 2 cycles after the vs rise; gen_reset high for 5 cycles; applied pulses; h_total_o=858.
3. Write h_total=100 with h_sync+h_bp+h_fp=160, then commit -> err=1 within 2 cycles, busy back low, actives unchanged. A following valid commit clears err.
4. interlaced=1, v_total_1=0, commit -> err=1. Same setup with interlaced=0 -> pass (set 1 ignored).
5. TIMEOUT=50, commit with vs_in stuck low -> APPLY on cycle 50 of WAIT_VS, applied pulses.
6. During WAIT_VS, write h_total=1000, then assert reset -> the write is ignored, then reset restores defaults; busy low and no apply until a new commit.
